// File: rtl/wb_pkg.sv
// Shared opcode constants, flag bit positions and opcode classification
// used by the writeback stage.
package wb_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b11001;
  localparam logic [4:0] OP_STORE = 5'b11010;
  localparam logic [4:0] OP_JMP   = 5'b11100;
  localparam logic [4:0] OP_CMP   = 5'b10110;

  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 0;

  function automatic logic is_reg_write(input logic [4:0] opcode);
    return !(opcode inside {OP_NOP, OP_STORE, OP_JMP, OP_CMP});
  endfunction

  function automatic logic is_flag_set(input logic [4:0] opcode);
    return !(opcode inside {OP_NOP, OP_LOAD, OP_STORE, OP_JMP});
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback bus: result, flags, destination and the stage hold.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              valid_e_in;
  logic [4:0]        opcode_e_in;
  logic [ADDR_W-1:0] dest_e_in;
  logic [DATA_W-1:0] data_result_e_in;
  logic [2:0]        flags_e_in;
  logic              stall_in;

  modport master (
    output valid_e_in, opcode_e_in, dest_e_in, data_result_e_in, flags_e_in, stall_in
  );
  modport slave (
    input  valid_e_in, opcode_e_in, dest_e_in, data_result_e_in, flags_e_in, stall_in
  );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports,
// R0 reads as zero and ignores writes.
module wb_regfile #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/writeback_stage.sv
// Fourth pipeline stage: W register, commit to register file and flags,
// bypassed read ports for decode and a retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  writeback_stage_if.slave    ex,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_dest,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [2:0]          flags_out,
  output logic [CNT_W-1:0]    retired_count
);

  logic              vld_p1;
  logic [4:0]        opcode_p1;
  logic [ADDR_W-1:0] dest_p1;
  logic [DATA_W-1:0] data_p1;
  logic [2:0]        flags_p1;

  logic              commit;
  logic              we_p1;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  // ---- W register: capture execute outputs unless held ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= OP_NOP;
    end else if (!ex.stall_in) begin
      vld_p1    <= ex.valid_e_in;
      opcode_p1 <= ex.opcode_e_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!ex.stall_in) begin
      dest_p1  <= ex.dest_e_in;
      data_p1  <= ex.data_result_e_in;
      flags_p1 <= ex.flags_e_in;
    end
  end

  assign commit = vld_p1 && !ex.stall_in;
  assign we_p1  = vld_p1 && is_reg_write(opcode_p1);

  // ---- Commit: architectural state updates at the closing edge of W ----
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_out     <= 3'b000;
      retired_count <= '0;
    end else if (commit) begin
      if (is_flag_set(opcode_p1)) flags_out <= flags_p1;
      if (opcode_p1 != OP_NOP)    retired_count <= retired_count + CNT_W'(1);
    end
  end

  wb_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (commit && we_p1),
    .wr_addr   (dest_p1),
    .wr_data   (data_p1),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b)
  );

  // fwd_valid already excludes R0, so it doubles as the bypass qualifier
  assign fwd_valid = we_p1 && (dest_p1 != '0);
  assign fwd_dest  = dest_p1;
  assign fwd_data  = data_p1;

  assign rd_data_a = (fwd_valid && (dest_p1 == rd_addr_a)) ? data_p1 : rf_a;
  assign rd_data_b = (fwd_valid && (dest_p1 == rd_addr_b)) ? data_p1 : rf_b;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for the main flow plus
// hand-written stall, counter-wrap and reset-during-stall sequences.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [2:0]  flags_out;
  logic [15:0] retired_count;

  int total = 0;
  int bad   = 0;

  writeback_stage_if #(.DATA_W(32), .ADDR_W(4)) ex_if ();

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex            (ex_if),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .fwd_valid     (fwd_valid),
    .fwd_dest      (fwd_dest),
    .fwd_data      (fwd_data),
    .flags_out     (flags_out),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  op;
    logic [3:0]  dest;
    logic [31:0] data;
    logic [2:0]  fl;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  ef;
    logic [15:0] ec;
    logic        efwd;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] dest,
                       input logic [31:0] data, input logic [2:0] fl);
    ex_if.valid_e_in       = v;
    ex_if.opcode_e_in      = op;
    ex_if.dest_e_in        = dest;
    ex_if.data_result_e_in = data;
    ex_if.flags_e_in       = fl;
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
  endtask

  initial begin
    // Each row: instruction captured at this edge; checks see the commit of the previous row
    tv[0] = '{1'b1, 5'b00001, 4'd5, 32'h0000_00AA, 3'b010, 4'd5, 4'd0, 32'h0000_00AA, 32'h0,          3'b000, 16'd0, 1'b1};
    tv[1] = '{1'b1, 5'b11001, 4'd3, 32'h1234_5678, 3'b111, 4'd5, 4'd3, 32'h0000_00AA, 32'h1234_5678, 3'b010, 16'd1, 1'b1};
    tv[2] = '{1'b1, 5'b00010, 4'd5, 32'h0000_00BB, 3'b001, 4'd5, 4'd3, 32'h0000_00BB, 32'h1234_5678, 3'b010, 16'd2, 1'b1};
    tv[3] = '{1'b1, 5'b11010, 4'd4, 32'h0000_DEAD, 3'b100, 4'd4, 4'd5, 32'h0,          32'h0000_00BB, 3'b001, 16'd3, 1'b0};
    tv[4] = '{1'b1, 5'b00001, 4'd0, 32'h0000_FFFF, 3'b100, 4'd0, 4'd4, 32'h0,          32'h0,          3'b001, 16'd4, 1'b0};
    tv[5] = '{1'b1, 5'b00000, 4'd6, 32'h0000_0077, 3'b111, 4'd0, 4'd6, 32'h0,          32'h0,          3'b100, 16'd5, 1'b0};
    tv[6] = '{1'b1, 5'b10110, 4'd6, 32'h0000_0099, 3'b011, 4'd6, 4'd5, 32'h0,          32'h0000_00BB, 3'b100, 16'd5, 1'b0};
    tv[7] = '{1'b0, 5'b00001, 4'd6, 32'h0000_0011, 3'b000, 4'd6, 4'd3, 32'h0,          32'h1234_5678, 3'b011, 16'd6, 1'b0};
    tv[8] = '{1'b0, 5'b00001, 4'd6, 32'h0000_0011, 3'b000, 4'd5, 4'd0, 32'h0000_00BB, 32'h0,          3'b011, 16'd6, 1'b0};

    rst = 1'b1;
    ex_if.stall_in = 1'b0;
    drive(1'b0, 5'b0, 4'd0, 32'h0, 3'b0);
    rd_addr_a = '0;
    rd_addr_b = '0;

    // ---- reset state ----
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      read_ab(4'(i), 4'(15 - i));
      chk("reset_rd_a", rd_data_a, 32'h0);
      chk("reset_rd_b", rd_data_b, 32'h0);
    end
    chk("reset_flags", 32'(flags_out), 32'h0);
    chk("reset_count", 32'(retired_count), 32'h0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'h0);
    rst = 1'b0;

    // ---- vector table ----
    for (int k = 0; k < 9; k++) begin
      drive(tv[k].v, tv[k].op, tv[k].dest, tv[k].data, tv[k].fl);
      step();
      read_ab(tv[k].ra, tv[k].rb);
      chk($sformatf("vec%0d_rd_a", k), rd_data_a, tv[k].ea);
      chk($sformatf("vec%0d_rd_b", k), rd_data_b, tv[k].eb);
      chk($sformatf("vec%0d_flags", k), 32'(flags_out), 32'(tv[k].ef));
      chk($sformatf("vec%0d_count", k), 32'(retired_count), 32'(tv[k].ec));
      chk($sformatf("vec%0d_fwd_valid", k), 32'(fwd_valid), 32'(tv[k].efwd));
    end
    read_ab(4'd5, 4'd0);
    chk("fwd_dest_bubble_w", 32'(fwd_valid), 32'h0);

    // ---- stall: W holds dest 7 while upstream changes ----
    drive(1'b1, 5'b00001, 4'd7, 32'h0000_0055, 3'b101);
    step();
    chk("stall_capture_fwd_dest", 32'(fwd_dest), 32'd7);
    chk("stall_capture_fwd_data", fwd_data, 32'h0000_0055);
    ex_if.stall_in = 1'b1;
    drive(1'b1, 5'b00001, 4'd8, 32'h0000_0066, 3'b000);
    for (int s = 0; s < 4; s++) begin
      step();
      read_ab(4'd8, 4'd7);
      chk($sformatf("stall%0d_count", s), 32'(retired_count), 32'd6);
      chk($sformatf("stall%0d_bypass_b", s), rd_data_b, 32'h0000_0055);
      chk($sformatf("stall%0d_rd_a_ignored", s), rd_data_a, 32'h0);
      chk($sformatf("stall%0d_fwd_dest", s), 32'(fwd_dest), 32'd7);
      chk($sformatf("stall%0d_flags", s), 32'(flags_out), 32'b011);
    end
    ex_if.stall_in = 1'b0;
    drive(1'b0, 5'b00001, 4'd8, 32'h0000_0066, 3'b000);
    step();
    read_ab(4'd7, 4'd8);
    chk("release_count", 32'(retired_count), 32'd7);
    chk("release_flags", 32'(flags_out), 32'b101);
    chk("release_r7", rd_data_a, 32'h0000_0055);
    chk("release_r8", rd_data_b, 32'h0);
    step();
    chk("release_single_commit", 32'(retired_count), 32'd7);

    // ---- counter wrap: 65535 ALU ops, then one more ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 5'b00001, 4'd1, 32'h0000_0001, 3'b000);
    for (int n = 0; n < 65535; n++) @(posedge clk);
    #2;
    drive(1'b0, 5'b00001, 4'd1, 32'h0, 3'b000);
    step();
    chk("wrap_preload", 32'(retired_count), 32'h0000_FFFF);
    drive(1'b1, 5'b00001, 4'd1, 32'h0000_0002, 3'b000);
    step();
    drive(1'b0, 5'b00001, 4'd1, 32'h0, 3'b000);
    step();
    chk("wrap_to_zero", 32'(retired_count), 32'h0);

    // ---- reset during stall with W valid ----
    drive(1'b1, 5'b00001, 4'd9, 32'h0000_0099, 3'b111);
    step();
    ex_if.stall_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_ab(4'd9, 4'd1);
    chk("rst_stall_count", 32'(retired_count), 32'h0);
    chk("rst_stall_flags", 32'(flags_out), 32'h0);
    chk("rst_stall_fwd_valid", 32'(fwd_valid), 32'h0);
    chk("rst_stall_r9", rd_data_a, 32'h0);
    chk("rst_stall_r1", rd_data_b, 32'h0);
    ex_if.stall_in = 1'b0;
    drive(1'b0, 5'b00001, 4'd9, 32'h0, 3'b000);
    step();
    read_ab(4'd9, 4'd0);
    chk("rst_stall_no_commit_count", 32'(retired_count), 32'h0);
    chk("rst_stall_no_commit_r9", rd_data_a, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Fourth pipeline stage. Consumes the execute stage's result, flags and destination outputs and holds them in one W pipeline register.
- Commits the held result to a 16x32 register file and a 3-bit flags register.
- Provides decode with two bypassed register read ports and a forwarding tap.
- Maintains a retired-instruction counter.

Parameters:
- NUM_REGS, 16, register-file depth; dest and read addresses are clog2(NUM_REGS) = 4 bits.
- DATA_W, 32, datapath width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_e_in  in  1  execute outputs below carry a live instruction.
- opcode_e_in  in  5  opcode accompanying the result.
- dest_e_in  in  4  destination register index.
- data_result_e_in  in  32  execute result (immediate data for LOAD).
- flags_e_in  in  3  {zero, sign, carry} from execute.
- stall_in  in  1  freeze the stage (hazard/memory hold).
- rd_addr_a  in  4  read port A address.
- rd_addr_b  in  4  read port B address.
- rd_data_a  out  32  read port A data, combinational.
- rd_data_b  out  32  read port B data, combinational.
- fwd_valid  out  1  W holds a register-writing instruction.
- fwd_dest  out  4  W destination.
- fwd_data  out  32  W data.
- flags_out  out  3  architectural flags {zero, sign, carry}, registered.
- retired_count  out  16  committed-instruction count.

Behaviour:
- Reset (rst=1 at an edge): all 16 registers <= 0; w_valid <= 0; flags_out <= 3'b000; retired_count <= 0. Reset overrides stall_in and any pending commit.
- W capture: when stall_in=0, W <= {valid_e_in, opcode, dest, data, flags} every cycle (bubble if valid_e_in=0).
  - When stall_in=1, W holds unchanged and upstream inputs are ignored.
- Commit: occurs in the cycle where w_valid=1 and stall_in=0, at the closing edge.
  - If w_we=1 and w_dest!=0: regfile[w_dest] <= w_data.
  - If the opcode is flag-setting: flags_out <= w_flags.
  - retired_count <= retired_count+1, wrapping FFFF->0000.
  - NOP (00000) does not increment the count.
- Latency: input sampled at edge N is committed at edge N+1 (no stall). Visible via bypass during cycle N..N+1; visible via the array from cycle N+1 onward.
- w_we = w_valid and opcode not in {NOP 00000, STORE 11010, JMP 11100, CMP 10110}.
- Flag-setting opcodes: all except NOP, LOAD 11001, STORE, JMP.
- R0 is hardwired zero. Reads of address 0 return 0. Writes to R0 are dropped but still retire.
- Read ports:
  - If w_we=1, w_dest==rd_addr and rd_addr!=0, return w_data (bypass). This applies regardless of stall_in.
  - Otherwise return regfile[rd_addr].
  - A and B are independent; both may hit the bypass simultaneously.
- fwd_valid = w_we and (w_dest!=0); fwd_dest/fwd_data mirror W.
- Stall held for many cycles: no repeated commit and no count increment. Exactly one commit follows release.
- Back-to-back writes to the same register: last-in wins. The bypass always shows the younger W value over the array.
- flags_out changes only on commit edges.

Decomposition:
- Package wb_pkg:
  - Opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_CMP.
  - Functions is_reg_write(opcode) and is_flag_set(opcode).
  - FLAG_Z/FLAG_S/FLAG_C bit indices.
- One sub-module, wb_regfile: 16x32 array with synchronous reset, one write port, two combinational read ports, and R0-zero logic. Bypass muxing lives in the top.

Test Plan:
- Reset: rst=1 for 2 cycles → rd_data_a/b=0 for all addresses, flags_out=000, retired_count=0, fwd_valid=0.
- ADD-class write:
  - Cycle 0 inputs: valid=1, opcode=00001, dest=5, data=0x0000_00AA, flags=010.
  - Cycle 1: rd_addr_a=5 → 0xAA via bypass, fwd_valid=1, fwd_dest=5.
  - After edge 2: rd_data_a=0xAA from array, flags_out=010, retired_count=1.
- LOAD: opcode=11001, dest=3, data=0x1234_5678 with flags_out previously 010 → R3=0x12345678, flags_out stays 010.
- Stall: capture dest=7, data=0x55, then hold stall_in=1 for 4 cycles.
  - During stall: retired_count unchanged, rd_addr_b=7 → 0x55 via bypass, upstream changes ignored.
  - After release: exactly +1 retire.
- R0/STORE/NOP:
  - dest=0, data=0xFFFF → R0 reads 0, count+1.
  - STORE dest=4 → R4 unchanged, fwd_valid=0.
  - NOP → count unchanged.
- Wrap and reset: preload retired_count=FFFF by running 65535 ALU ops, one more → 0000. Assert rst during a stall with W valid → no commit, all state cleared.
